// File: rtl/hit_judge_if.sv
// Bundle of lane lights, player buttons, judgement pulses and counters
// exchanged between the game controller and the hit judge.
interface hit_judge_if #(
   parameter int SCORE_W = 16,
   parameter int COMBO_W = 8
);
   logic               game_en;
   logic               line1;
   logic               line2;
   logic               line3;
   logic               btn1;
   logic               btn2;
   logic               btn3;
   logic [2:0]         hit;
   logic [2:0]         miss;
   logic [2:0]         stray;
   logic [SCORE_W-1:0] score;
   logic [COMBO_W-1:0] combo;
   logic [COMBO_W-1:0] max_combo;

   modport master (
      output game_en, line1, line2, line3, btn1, btn2, btn3,
      input  hit, miss, stray, score, combo, max_combo
   );

   modport slave (
      input  game_en, line1, line2, line3, btn1, btn2, btn3,
      output hit, miss, stray, score, combo, max_combo
   );
endinterface

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: synchronises three player buttons, runs one
// judgement FSM per lane and keeps saturating score / combo / max-combo.
module hit_judge #(
   parameter int SCORE_W = 16,
   parameter int COMBO_W = 8
) (
   input logic         clk,
   input logic         reset,
   hit_judge_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      WINDOW,
      DONE
   } lane_state_t;

   logic [2:0] line;
   logic [2:0] btn;

   logic [2:0] sync1;
   logic [2:0] sync2;
   logic [2:0] delay;
   logic [2:0] press;

   lane_state_t state [3];
   lane_state_t state_next [3];

   logic [2:0] hit_q;
   logic [2:0] miss_q;
   logic [2:0] stray_q;
   logic [2:0] hit_next;
   logic [2:0] miss_next;
   logic [2:0] stray_next;

   logic [SCORE_W-1:0] score_q;
   logic [COMBO_W-1:0] combo_q;
   logic [COMBO_W-1:0] max_combo_q;
   logic [SCORE_W-1:0] score_next;
   logic [COMBO_W-1:0] combo_next;
   logic [SCORE_W:0]   score_sum;
   logic [COMBO_W:0]   combo_sum;
   logic [1:0]         hit_count;

   function automatic logic [1:0] count3(input logic [2:0] v);
      count3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   assign line = {bus.line3, bus.line2, bus.line1};
   assign btn  = {bus.btn3, bus.btn2, bus.btn1};

   // Button synchroniser, edge detector and a press register so that a
   // press reaches the lane FSMs three edges after the button is first seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         delay <= '0;
         press <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         delay <= sync2;
         press <= sync2 & ~delay;
      end
   end

   // Lane judgement: decide each lane's next state and which pulse it fires.
   always_comb begin
      hit_next   = '0;
      miss_next  = '0;
      stray_next = '0;
      for (int i = 0; i < 3; i++) begin
         state_next[i] = state[i];
         if (!bus.game_en) begin
            state_next[i] = IDLE;
         end else begin
            case (state[i])
               IDLE: begin
                  if (line[i] && press[i]) begin
                     state_next[i] = DONE;
                     hit_next[i]   = 1'b1;
                  end else if (line[i]) begin
                     state_next[i] = WINDOW;
                  end else if (press[i]) begin
                     stray_next[i] = 1'b1;
                  end
               end
               WINDOW: begin
                  if (press[i]) begin
                     state_next[i] = DONE;
                     hit_next[i]   = 1'b1;
                  end else if (!line[i]) begin
                     state_next[i] = IDLE;
                     miss_next[i]  = 1'b1;
                  end
               end
               DONE: begin
                  if (!line[i]) begin
                     state_next[i] = IDLE;
                  end
               end
               default: begin
                  state_next[i] = IDLE;
               end
            endcase
         end
      end
   end

   // Lane state and judgement pulses move together on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= IDLE;
         end
         hit_q   <= '0;
         miss_q  <= '0;
         stray_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= state_next[i];
         end
         hit_q   <= hit_next;
         miss_q  <= miss_next;
         stray_q <= stray_next;
      end
   end

   // Saturating score and combo arithmetic driven by last cycle's pulses.
   always_comb begin
      hit_count  = count3(hit_q);
      score_sum  = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, hit_count};
      combo_sum  = {1'b0, combo_q} + {{(COMBO_W-1){1'b0}}, hit_count};
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      combo_next = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
      if (|(miss_q | stray_q)) begin
         combo_next = '0;
      end
   end

   // Counters advance only while judging is enabled; max tracks the best combo.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q     <= '0;
         combo_q     <= '0;
         max_combo_q <= '0;
      end else if (bus.game_en) begin
         score_q <= score_next;
         combo_q <= combo_next;
         if (combo_next > max_combo_q) begin
            max_combo_q <= combo_next;
         end
      end
   end

   assign bus.hit       = hit_q;
   assign bus.miss      = miss_q;
   assign bus.stray     = stray_q;
   assign bus.score     = score_q;
   assign bus.combo     = combo_q;
   assign bus.max_combo = max_combo_q;

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter SCORE_W, default 16: score counter width.
REQ-002 Parameter COMBO_W, default 8: combo and max-combo counter width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 game_en  input  1  high = judging active; low = all lane FSMs held in IDLE, counters hold.
REQ-006 line1, line2, line3  input  1 each  lane note lights from the light manager; synchronous to clk; high = note present on lane.
REQ-007 btn1, btn2, btn3  input  1 each  raw player buttons; asynchronous; high = pressed.
REQ-008 hit  output  3  registered one-cycle pulse per lane (bit0 = lane1): note hit.
REQ-009 miss  output  3  registered one-cycle pulse per lane: note expired unhit.
REQ-010 stray  output  3  registered one-cycle pulse per lane: press with no note.
REQ-011 score  output  SCORE_W  total hits, saturating.
REQ-012 combo  output  COMBO_W  current consecutive-hit run, saturating.
REQ-013 max_combo  output  COMBO_W  largest combo value since reset.

Function
REQ-014 Each btnN SHALL pass through a 2-flop synchronizer (s1, s2) and a delay flop d; press_N = s2 & ~d.
REQ-015 Each lane SHALL have an FSM with states IDLE, WINDOW, DONE, evaluated only when game_en = 1.
REQ-016 IDLE: line=1 & press=0 -> WINDOW; line=1 & press=1 -> DONE with hit; line=0 & press=1 -> IDLE with stray; else stay.
REQ-017 WINDOW: press=1 -> DONE with hit, regardless of line; press=0 & line=0 -> IDLE with miss; else stay.
REQ-018 DONE: line=0 -> IDLE; press ignored (no stray, no second hit); else stay.
REQ-019 hit/miss/stray bits SHALL be registered on the same edge as the FSM transition and be high for exactly one cycle.
REQ-020 Latency: a btn rising edge first sampled at edge k SHALL produce hit (or stray) high during the cycle after edge k+3.
REQ-021 score SHALL add popcount(hit) on the cycle after the hit pulse, saturating at 2^SCORE_W-1.
REQ-022 combo update on the cycle after the pulses: any miss or stray bit set -> 0; else combo + popcount(hit), saturating at 2^COMBO_W-1.
REQ-023 A simultaneous hit on one lane and miss/stray on another SHALL still add the hits to score, and combo SHALL become 0.
REQ-024 max_combo SHALL update to combo's new value in the same cycle combo changes whenever the new value exceeds max_combo.
REQ-025 game_en = 0: FSMs forced to IDLE, pulse outputs 0, score/combo/max_combo hold; synchronizers keep running.
REQ-026 game_en 1->0 while in WINDOW SHALL NOT produce a miss.
REQ-027 No output SHALL depend combinationally on any input.

Reset
REQ-028 On reset = 1 at a rising edge: FSMs -> IDLE; synchronizer and delay flops -> 0; hit, miss, stray, score, combo, max_combo -> 0.
REQ-029 Reset SHALL take priority over game_en and all lane events in the same cycle.
REQ-030 Reset asserted mid-WINDOW SHALL discard the note with no miss pulse.
REQ-031 A button already held high when reset deasserts SHALL register one press after synchronization; no other press is reported until it is released and pressed again.

Verification
REQ-032 line1 high 10 cycles, btn1 rises at cycle 3 -> hit=3'b001 for one cycle at cycle 6, score=1, combo=1, max_combo=1; no miss.
REQ-033 line2 high 5 cycles, no press -> miss=3'b010 one cycle after line2 falls; combo=0; score unchanged.
REQ-034 btn3 pressed with line3 low -> stray=3'b100, combo 4 -> 0, max_combo stays 4.
REQ-035 Hits on lanes 1 and 3 plus a miss on lane 2 in the same cycle -> score +2, combo=0.
REQ-036 SCORE_W=4: 17 hits -> score saturates at 15; COMBO_W=4: combo saturates at 15.
REQ-037 Reset pulsed while lane1 is in WINDOW -> all outputs 0 next cycle, no miss pulse, line1 still high -> re-enters WINDOW.
